// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the CPU run/halt/step controller.
// State encoding and default widths.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  localparam int CYC_W_DEF  = 32;
  localparam int STEP_W_DEF = 8;

endpackage

// File: rtl/cpu_step_ctrl_bp_match.sv
// PC breakpoint comparator.
// Skip masks the match once so a resumed CPU can leave the breakpoint.
module bp_match (
  input  logic        en,
  input  logic        skip,
  input  logic [31:0] addr,
  input  logic [31:0] pc,
  output logic        hit
);

  assign hit = en & (pc == addr) & ~skip;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/halt/single-step controller producing the CPU clock enable.
// Also holds the sticky breakpoint flag and the retired counter.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CYC_W  = CYC_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              cmd_run,
  input  logic              cmd_halt,
  input  logic              cmd_step,
  input  logic [STEP_W-1:0] step_count,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       PC,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              halted,
  output logic              bp_hit,
  output logic [CYC_W-1:0]  retired
);

  state_t            st;
  logic [STEP_W-1:0] remaining;
  logic              bp_skip;
  logic              match;

  bp_match u_bp (
    .en   (bp_en),
    .skip (bp_skip),
    .addr (bp_addr),
    .pc   (PC),
    .hit  (match)
  );

  assign cpu_en = (st != HALT) & ~match;
  assign state  = st;
  assign halted = (st == HALT);

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      st        <= HALT;
      remaining <= '0;
      bp_skip   <= 1'b0;
      bp_hit    <= 1'b0;
      retired   <= '0;
    end else begin
      if (cpu_en) begin
        retired <= retired + CYC_W'(1);
        bp_skip <= 1'b0;
      end
      unique case (st)
        HALT: begin
          if (cmd_halt) begin
            st <= HALT;
          end else if (cmd_step) begin
            st        <= STEP;
            remaining <= (step_count == '0)
                         ? STEP_W'(1) : step_count;
            bp_skip   <= 1'b1;
            bp_hit    <= 1'b0;
          end else if (cmd_run) begin
            st      <= RUN;
            bp_skip <= 1'b1;
            bp_hit  <= 1'b0;
          end
        end
        RUN, STEP: begin
          if (st == STEP && cpu_en)
            remaining <= remaining - STEP_W'(1);
          // A breakpoint wins over halt so bp_hit is always recorded
          if (match) begin
            st     <= HALT;
            bp_hit <= 1'b1;
          end else if (cmd_halt) begin
            st <= HALT;
          end else if (st == STEP && cpu_en
                       && remaining == STEP_W'(1)) begin
            st <= HALT;
          end
        end
        default: st <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Self-checking bench for cpu_step_ctrl: directed scenarios
// plus randomized commands against a behavioural model.
module tb_cpu_step_ctrl;

  logic        Clock;
  logic        Resetn;
  logic        cmd_run, cmd_halt, cmd_step;
  logic [7:0]  step_count;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] PC;

  logic        cpu_en, halted, bp_hit;
  logic [1:0]  state;
  logic [31:0] retired;

  logic        cpu_en_w, halted_w, bp_hit_w;
  logic [1:0]  state_w;
  logic [3:0]  retired_w;

  int checks = 0;
  int failures = 0;

  cpu_step_ctrl dut (
    .Clock(Clock), .Resetn(Resetn),
    .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
    .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .PC(PC), .cpu_en(cpu_en), .state(state), .halted(halted),
    .bp_hit(bp_hit), .retired(retired)
  );

  cpu_step_ctrl #(.CYC_W(4)) dut_w (
    .Clock(Clock), .Resetn(Resetn),
    .cmd_run(cmd_run), .cmd_halt(cmd_halt), .cmd_step(cmd_step),
    .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .PC(PC), .cpu_en(cpu_en_w), .state(state_w), .halted(halted_w),
    .bp_hit(bp_hit_w), .retired(retired_w)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Model: mode 0=halted 1=running 2=stepping, budget = steps left
  int              m_mode;
  int              m_left;
  bit              m_skip;
  bit              m_hit;
  longint unsigned m_ret;

  function automatic bit m_match();
    return bp_en && (PC == bp_addr) && !m_skip;
  endfunction

  function automatic bit m_en();
    return (m_mode != 0) && !m_match();
  endfunction

  function automatic void m_reset();
    m_mode = 0; m_left = 0; m_skip = 0; m_hit = 0; m_ret = 0;
  endfunction

  function automatic void m_edge();
    bit mt;
    bit en;
    mt = m_match();
    en = (m_mode != 0) && !mt;
    if (en) begin
      m_ret++;
      m_skip = 0;
      if (m_mode == 2) m_left--;
    end
    if (m_mode == 0) begin
      if (cmd_halt) begin
      end else if (cmd_step) begin
        m_mode = 2;
        m_left = (step_count == 0) ? 1 : int'(step_count);
        m_skip = 1; m_hit = 0;
      end else if (cmd_run) begin
        m_mode = 1; m_skip = 1; m_hit = 0;
      end
    end else if (mt) begin
      m_mode = 0; m_hit = 1;
    end else if (cmd_halt) begin
      m_mode = 0;
    end else if (m_mode == 2 && m_left == 0) begin
      m_mode = 0;
    end
  endfunction

  // One clock: model follows the edge, fetch advances PC when enabled
  task automatic cycle();
    bit en;
    en = m_en();
    m_edge();
    @(posedge Clock);
    #1;
    cmd_run = 0; cmd_halt = 0; cmd_step = 0;
    if (en) PC = (PC + 32'd4) & 32'h3c;
    #1;
  endtask

  task automatic do_reset();
    Resetn = 1; cmd_run = 0; cmd_halt = 0; cmd_step = 0;
    @(posedge Clock);
    #1;
    m_reset();
    PC = 0;
    Resetn = 0;
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1; bp_en = 0; bp_addr = 0; PC = 0; step_count = 0;
    cmd_run = 0; cmd_halt = 0; cmd_step = 0;
    #2;
    checks++;
    if (state !== 2'b00 || cpu_en !== 1'b0 || halted !== 1'b1
        || bp_hit !== 1'b0 || retired !== 32'd0) begin
      failures++;
      $display("FAIL reset st=%b en=%b h=%b hit=%b ret=%0d exp 00/0/1/0/0",
               state, cpu_en, halted, bp_hit, retired);
    end
    @(posedge Clock);
    #1;
    m_reset();
    Resetn = 0;
    #1;
  endtask

  task automatic test_run();
    int n;
    do_reset();
    checks++;
    if (state !== 2'b00 || cpu_en !== 1'b0) begin
      failures++;
      $display("FAIL run_pre st=%b en=%b exp 00/0", state, cpu_en);
    end
    cmd_run = 1;
    cycle();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_en === 1'b1) n++;
      cycle();
    end
    checks++;
    if (n != 10 || retired !== 32'd10) begin
      failures++;
      $display("FAIL run_10 en_cycles=%0d ret=%0d exp 10/10", n, retired);
    end
    cmd_halt = 1;
    cycle();
    checks++;
    if (halted !== 1'b1 || retired !== 32'd11) begin
      failures++;
      $display("FAIL run_halt h=%b ret=%0d exp 1/11", halted, retired);
    end
  endtask

  task automatic test_step(input int n);
    int cnt;
    int exp_n;
    longint unsigned base;
    exp_n = (n == 0) ? 1 : n;
    base = m_ret;
    step_count = 8'(n);
    cmd_step = 1;
    cycle();
    checks++;
    if (state !== 2'b10) begin
      failures++;
      $display("FAIL step%0d_state got=%b exp=10", n, state);
    end
    cnt = 0;
    for (int k = 0; k < 300; k++) begin
      if (cpu_en !== 1'b1) break;
      cnt++;
      cycle();
    end
    checks++;
    if (cnt != exp_n || halted !== 1'b1
        || retired !== 32'(base + longint'(exp_n))) begin
      failures++;
      $display("FAIL step%0d cnt=%0d h=%b ret=%0d exp %0d/1/%0d",
               n, cnt, halted, retired, exp_n, base + exp_n);
    end
  endtask

  task automatic test_breakpoint();
    do_reset();
    bp_en = 1; bp_addr = 32'h10;
    cmd_run = 1;
    cycle();
    for (int k = 0; k < 20 && cpu_en === 1'b1; k++) cycle();
    checks++;
    if (PC !== 32'h10 || cpu_en !== 1'b0) begin
      failures++;
      $display("FAIL bp_stop pc=%h en=%b exp 10/0", PC, cpu_en);
    end
    cycle();
    checks++;
    if (state !== 2'b00 || bp_hit !== 1'b1 || retired !== 32'd4) begin
      failures++;
      $display("FAIL bp_halt st=%b hit=%b ret=%0d exp 00/1/4",
               state, bp_hit, retired);
    end
    step_count = 1;
    cmd_step = 1;
    cycle();
    checks++;
    if (bp_hit !== 1'b0 || cpu_en !== 1'b1) begin
      failures++;
      $display("FAIL bp_resume hit=%b en=%b exp 0/1", bp_hit, cpu_en);
    end
    cycle();
    checks++;
    if (PC !== 32'h14 || halted !== 1'b1 || retired !== 32'd5) begin
      failures++;
      $display("FAIL bp_after pc=%h h=%b ret=%0d exp 14/1/5",
               PC, halted, retired);
    end
  endtask

  task automatic test_simultaneous();
    int cnt;
    do_reset();
    bp_en = 0;
    step_count = 2; cmd_run = 1; cmd_step = 1;
    cycle();
    checks++;
    if (state !== 2'b10) begin
      failures++;
      $display("FAIL simul_state got=%b exp=10", state);
    end
    cnt = 0;
    for (int k = 0; k < 20 && cpu_en === 1'b1; k++) begin
      cnt++;
      cycle();
    end
    checks++;
    if (cnt != 2 || halted !== 1'b1) begin
      failures++;
      $display("FAIL simul_cnt got=%0d h=%b exp 2/1", cnt, halted);
    end
    bp_en = 1;
    bp_addr = (PC + 32'd8) & 32'h3c;
    cmd_run = 1;
    cycle();
    for (int k = 0; k < 20 && PC !== bp_addr; k++) cycle();
    cmd_halt = 1;
    cycle();
    checks++;
    if (state !== 2'b00 || bp_hit !== 1'b1) begin
      failures++;
      $display("FAIL halt_and_bp st=%b hit=%b exp 00/1", state, bp_hit);
    end
    bp_en = 0;
  endtask

  task automatic test_halt_during_step();
    longint unsigned base;
    do_reset();
    bp_en = 0;
    base = m_ret;
    step_count = 5; cmd_step = 1;
    cycle();
    cycle();
    cycle();
    cmd_halt = 1;
    cycle();
    checks++;
    if (halted !== 1'b1 || bp_hit !== 1'b0
        || retired !== 32'(base + 3)) begin
      failures++;
      $display("FAIL halt_step h=%b hit=%b ret=%0d exp 1/0/%0d",
               halted, bp_hit, retired, base + 3);
    end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    bp_en = 0;
    cmd_run = 1;
    cycle();
    for (int i = 0; i < 17; i++) cycle();
    checks++;
    if (retired_w !== 4'd1 || retired !== 32'd17) begin
      failures++;
      $display("FAIL wrap ret_w=%0d ret=%0d exp 1/17", retired_w, retired);
    end
    #2;
    Resetn = 1;
    #1;
    checks++;
    if (cpu_en_w !== 1'b0 || retired_w !== 4'd0 || state_w !== 2'b00
        || cpu_en !== 1'b0 || retired !== 32'd0) begin
      failures++;
      $display("FAIL async_rst en_w=%b ret_w=%0d st_w=%b en=%b ret=%0d",
               cpu_en_w, retired_w, state_w, cpu_en, retired);
    end
    m_reset();
    PC = 0;
    @(posedge Clock);
    #1;
    Resetn = 0;
    #1;
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      cmd_run  = ($urandom_range(0, 9) == 0);
      cmd_halt = ($urandom_range(0, 19) == 0);
      cmd_step = ($urandom_range(0, 9) == 0);
      step_count = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) bp_en = ~bp_en;
      if ($urandom_range(0, 15) == 0)
        bp_addr = 32'($urandom_range(0, 15)) << 2;
      #1;
      checks++;
      if (cpu_en !== m_en()) begin
        failures++;
        $display("FAIL rnd_en cyc=%0d got=%b exp=%b", i, cpu_en, m_en());
      end
      cycle();
      checks++;
      if (state !== 2'(m_mode) || halted !== (m_mode == 0)
          || bp_hit !== m_hit || retired !== 32'(m_ret)
          || retired_w !== 4'(m_ret)) begin
        failures++;
        bad++;
        if (bad < 5)
          $display("FAIL rnd_regs cyc=%0d st=%b hit=%b ret=%0d exp %0d/%b/%0d",
                   i, state, bp_hit, retired, m_mode, m_hit, m_ret);
      end
    end
    bp_en = 0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_step(3);
    test_step(0);
    test_step(7);
    test_breakpoint();
    test_simultaneous();
    test_halt_during_step();
    test_wrap_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
